instr_mem_server: RTL and testbench
===================================

// Module: instr_mem_server
// PURPOSE
//  Program-memory responder on the CPU fetch interface. The CPU drives 'address'
//  (its PC) and this block returns 'instruction'. A byte-stream loader writes the
//  program over a valid/ready handshake. While no program is loaded, or a load is
//  in progress, the block returns a self-loop instruction so the CPU holds its PC.
// PARAMETERS
//  AW         8      address width; memory depth = 2**AW bytes
//  HOLD_INSTR 8'hC3  instruction returned when the CPU must hold (jump -1, then pc+1)
// PORTS
//  clk50        in   1    system clock; all state updates on the posedge
//  reset        in   1    asynchronous, active-low; 0 = reset asserted
//  load_start   in   1    1-cycle pulse; begins a new program load at address 0
//  load_data    in   8    program byte
//  load_valid   in   1    load_data is valid this cycle
//  load_last    in   1    qualifies load_data as the final program byte
//  load_ready   out  1    block accepts a byte this cycle
//  address      in   AW   CPU fetch address (PC)
//  instruction  out  8    registered instruction returned to the CPU
//  prog_len     out  AW+1 number of bytes in the loaded program (0..2**AW)
//  running      out  1    1 = state RUN (a program is valid)
//  truncated    out  1    sticky: last load filled memory without load_last
// BEHAVIOUR
//  Reset (reset==0, asynchronous):
//   - state=IDLE, wr_ptr=0, prog_len=0, truncated=0.
//   - instruction=HOLD_INSTR, load_ready=0, running=0.
//   - Memory contents are not reset.
//  States:
//   - IDLE: no valid program. load_ready=0. load_start -> LOAD.
//   - LOAD: load_ready=1, except in the cycle load_start is seen.
//     A beat is accepted when load_valid && load_ready:
//     mem[wr_ptr]<=load_data, wr_ptr++, prog_len++.
//     Accepted beat with load_last=1 -> RUN.
//     Accepted beat at wr_ptr==2**AW-1 with load_last=0 -> RUN, truncated<=1.
//   - RUN: load_ready=0; load_valid is ignored. load_start -> LOAD.
//  load_start (any state, including LOAD or RUN):
//   - Next state LOAD; wr_ptr<=0, prog_len<=0, truncated<=0.
//   - Any load_valid in that same cycle is NOT accepted (load_ready=0).
//  Fetch path (1 clk50 cycle latency):
//   - RUN and address < prog_len: instruction <= mem[address].
//   - RUN and address >= prog_len: instruction <= HOLD_INSTR (CPU parks past end).
//   - IDLE or LOAD: instruction <= HOLD_INSTR.
//  Width rules:
//   - prog_len is AW+1 bits so a full memory (256) is representable.
//   - The address compare is unsigned, zero-extended to AW+1 bits.
//   - wr_ptr is AW bits and never wraps during a load; the full case ends the load.
//  Boundary cases:
//   - load_last on the 2**AW-th byte -> RUN, truncated stays 0.
//   - Empty load (load_start, then no beats) stays in LOAD with prog_len=0, HOLD out.
//   - Reset mid-load -> IDLE; partial bytes stay in memory but prog_len=0.
//   - Registered read: a write to mem[a] in LOAD is visible to the CPU only after RUN.
//   - A fetch in the first RUN cycle returns that cycle's mem value, no bypass needed.
// TESTING
//  1. Release reset, no load; address=0..5 -> instruction=8'hC3 every cycle,
//     running=0, load_ready=0.
//  2. load_start; beats 8'h01,8'h12,8'hC3 (last on 3rd) -> prog_len=3, running=1;
//     address=1 -> 8'h12 one cycle later; address=3 -> 8'hC3.
//  3. Stall loader: load_valid toggles 1,0,1 with load_ready=1 -> only 2 writes,
//     wr_ptr=2; load_start+load_valid same cycle -> byte dropped, prog_len=0.
//  4. Load 256 bytes (value = index), no load_last -> RUN, truncated=1,
//     prog_len=256, address=8'hFF -> 8'hFF.
//  5. Assert reset low after 10 of 20 beats -> state IDLE, prog_len=0,
//     instruction=8'hC3 asynchronously; reload 4 bytes -> correct reads.
//  6. In RUN, load_start -> instruction=8'hC3 the next cycle, running=0;
//     a new 2-byte program replaces the old one, address=2 -> 8'hC3.

Source files
------------

// File: rtl/instr_mem_server_if.sv
// Fetch and program-load bus between the CPU/loader side and instr_mem_server.
// master = CPU plus byte-stream loader; slave = the memory server.
interface instr_mem_server_if #(
    parameter int unsigned AW = 8
) ();
    logic          load_start;
    logic [7:0]    load_data;
    logic          load_valid;
    logic          load_last;
    logic          load_ready;
    logic [AW-1:0] address;
    logic [7:0]    instruction;
    logic [AW:0]   prog_len;
    logic          running;
    logic          truncated;

    modport master (
        output load_start, load_data, load_valid, load_last, address,
        input  load_ready, instruction, prog_len, running, truncated
    );

    modport slave (
        input  load_start, load_data, load_valid, load_last, address,
        output load_ready, instruction, prog_len, running, truncated
    );
endinterface

// File: rtl/instr_mem_server.sv
// Program memory for the CPU fetch port, written by a byte-stream loader.
// Returns HOLD_INSTR (a self-loop) whenever no valid program is present.
module instr_mem_server #(
    parameter int unsigned AW         = 8,
    parameter logic [7:0]  HOLD_INSTR = 8'hC3
) (
    input logic               clk50,
    input logic               reset,
    instr_mem_server_if.slave bus
);
    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   prog_len_q, prog_len_d;
    logic          truncated_q, truncated_d;
    logic [7:0]    instr_q, instr_d;
    logic [7:0]    mem [Depth];
    logic          load_ready;
    logic          accept;
    logic          at_end;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        prog_len_d  = prog_len_q;
        truncated_d = truncated_q;
        instr_d     = HOLD_INSTR;
        // A restart pulse blocks any beat presented in the same cycle.
        load_ready  = (state_q == StLoad) && !bus.load_start;
        accept      = bus.load_valid && load_ready;
        at_end      = (wr_ptr_q == {AW{1'b1}});

        if (bus.load_start) begin
            state_d     = StLoad;
            wr_ptr_d    = '0;
            prog_len_d  = '0;
            truncated_d = 1'b0;
        end else if (accept) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            prog_len_d = prog_len_q + 1'b1;
            if (bus.load_last) begin
                state_d = StRun;
            end else if (at_end) begin
                // Memory full without a last marker: run what we have.
                state_d     = StRun;
                truncated_d = 1'b1;
            end
        end

        if ((state_q == StRun) && ({1'b0, bus.address} < prog_len_q)) begin
            instr_d = mem[bus.address];
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            prog_len_q  <= '0;
            truncated_q <= 1'b0;
            instr_q     <= HOLD_INSTR;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            prog_len_q  <= prog_len_d;
            truncated_q <= truncated_d;
            instr_q     <= instr_d;
        end
    end

    // Contents deliberately survive reset.
    always_ff @(posedge clk50) begin
        if (accept) begin
            mem[wr_ptr_q] <= bus.load_data;
        end
    end

    assign bus.load_ready  = load_ready;
    assign bus.instruction = instr_q;
    assign bus.prog_len    = prog_len_q;
    assign bus.running     = (state_q == StRun);
    assign bus.truncated   = truncated_q;
endmodule

// File: tb/tb_instr_mem_server.sv
// Self-checking bench for instr_mem_server: a reference model predicts each fetch,
// expected instructions queue up when driven and are compared when registered.
module tb_instr_mem_server;
    localparam logic [7:0] Hold = 8'hC3;
    localparam int MIdle = 0;
    localparam int MLoad = 1;
    localparam int MRun  = 2;

    logic clk50 = 1'b0;
    logic reset = 1'b0;

    instr_mem_server_if #(.AW(8)) bus ();

    instr_mem_server #(
        .AW         (8),
        .HOLD_INSTR (Hold)
    ) dut (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk50 = ~clk50;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_mem [256];
    int         m_st    = MIdle;
    int         m_wp    = 0;
    int         m_len   = 0;
    logic       m_trunc = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, predict, then compare just after posedge.
    task automatic cycle(input logic start, input logic valid, input logic [7:0] data,
                         input logic last, input logic [7:0] addr);
        logic       exp_ready;
        logic [7:0] got_exp;
        @(negedge clk50);
        bus.load_start = start;
        bus.load_valid = valid;
        bus.load_data  = data;
        bus.load_last  = last;
        bus.address    = addr;
        exp_ready = (m_st == MLoad) && !start;
        exp_q.push_back(((m_st == MRun) && (int'(addr) < m_len)) ? m_mem[addr] : Hold);
        #1;
        check("load_ready", 32'(bus.load_ready), 32'(exp_ready));
        if (start) begin
            m_st = MLoad; m_wp = 0; m_len = 0; m_trunc = 1'b0;
        end else if (valid && exp_ready) begin
            m_mem[m_wp] = data;
            if (last) begin
                m_st = MRun;
            end else if (m_wp == 255) begin
                m_st = MRun; m_trunc = 1'b1;
            end
            m_wp++; m_len++;
        end
        @(posedge clk50);
        #1;
        got_exp = exp_q.pop_front();
        check("instruction", 32'(bus.instruction), 32'(got_exp));
        check("running", 32'(bus.running), 32'(m_st == MRun));
        check("prog_len", 32'(bus.prog_len), 32'(m_len));
        check("truncated", 32'(bus.truncated), 32'(m_trunc));
    endtask

    task automatic idle(input logic [7:0] addr);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, addr);
    endtask

    initial begin
        logic [7:0] prog2 [3];
        prog2[0] = 8'h01; prog2[1] = 8'h12; prog2[2] = 8'hC3;
        bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = 8'h00;
        bus.load_last  = 1'b0; bus.address    = '0;
        #12;
        check("reset_instr", 32'(bus.instruction), 32'(Hold));
        check("reset_running", 32'(bus.running), 32'd0);
        check("reset_prog_len", 32'(bus.prog_len), 32'd0);
        @(negedge clk50);
        reset = 1'b1;

        // No program: hold instruction on every address.
        for (int a = 0; a < 6; a++) idle(8'(a));

        // Three-byte program, last on third beat.
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, prog2[i], i == 2, 8'h00);
        idle(8'h01);
        idle(8'h03);
        idle(8'h00);
        idle(8'h02);
        check("prog_len_3", 32'(bus.prog_len), 32'd3);
        check("fetch_a1", 32'(m_mem[1]), 32'h12);

        // Stalled loader, then start colliding with a beat.
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'hA0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'hEE, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'hA1, 1'b0, 8'h00);
        check("stall_len", 32'(bus.prog_len), 32'd2);
        cycle(1'b1, 1'b1, 8'h55, 1'b0, 8'h00);
        check("drop_len", 32'(bus.prog_len), 32'd0);
        // Empty load stays in LOAD returning hold.
        idle(8'h00);
        idle(8'h01);

        // Full memory without load_last.
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h77, 1'b0, 8'hFF);
        idle(8'h80);
        check("full_trunc", 32'(bus.truncated), 32'd1);
        check("full_len", 32'(bus.prog_len), 32'd256);

        // Reset in the middle of a 20-beat load.
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 8'h00);
        #2;
        reset = 1'b0;
        #1;
        check("async_instr", 32'(bus.instruction), 32'(Hold));
        check("async_running", 32'(bus.running), 32'd0);
        check("async_len", 32'(bus.prog_len), 32'd0);
        check("async_ready", 32'(bus.load_ready), 32'd0);
        m_st = MIdle; m_wp = 0; m_len = 0; m_trunc = 1'b0;
        @(negedge clk50);
        reset = 1'b1;
        idle(8'h03);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'h90 + i), i == 3, 8'h00);
        for (int a = 0; a < 5; a++) idle(8'(a));

        // Restart from RUN replaces the program.
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h01);
        idle(8'h01);
        cycle(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h4D, 1'b1, 8'h00);
        idle(8'h02);
        idle(8'h00);
        idle(8'h01);
        check("restart_len", 32'(bus.prog_len), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
